// File: rtl/led_uart_tx.sv
// Logs every change on the LED bus through a small FIFO and sends each byte as a UART frame.
// Define LED_TX_PARITY_EN for 8E1 frames (even parity bit after the data); the default is 8N1.
module led_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [7:0]         iLed,
  output logic               oTx,
  output logic               oBusy,
  output logic               oOverflow,
  output logic [FIFO_AW:0]   oFifoCount
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef LED_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tState;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tState;
`endif

  tState              rState, stateNext;
  logic [BW-1:0]      rBaud, baudNext;
  logic [2:0]         rBitCnt, bitCntNext;
  logic [7:0]         rShift, shiftNext;
  logic               rTx, txNext;
  logic               rOverflow;
  logic [7:0]         rLast;
  logic [7:0]         rMem [DEPTH];
  logic [FIFO_AW-1:0] rWrPtr, rRdPtr;
  logic [FIFO_AW:0]   rCount;
  logic               fifoEmpty, fifoFull, change, doPush, pop, baudEnd;
`ifdef LED_TX_PARITY_EN
  logic               rParity, parityNext;
`endif

  assign fifoEmpty = (rCount == '0);
  assign fifoFull  = (rCount == (FIFO_AW+1)'(DEPTH));
  assign change    = (iLed != rLast);
  assign doPush    = change && !fifoFull;
  assign baudEnd   = (rBaud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    stateNext  = rState;
    baudNext   = baudEnd ? '0 : rBaud + 1'b1;
    bitCntNext = rBitCnt;
    shiftNext  = rShift;
    pop        = 1'b0;
`ifdef LED_TX_PARITY_EN
    parityNext = rParity;
`endif
    case (rState)
      IDLE: begin
        baudNext = '0;
        if (!fifoEmpty) begin
          pop        = 1'b1;
          shiftNext  = rMem[rRdPtr];
          bitCntNext = '0;
          stateNext  = START;
`ifdef LED_TX_PARITY_EN
          parityNext = ^rMem[rRdPtr];
`endif
        end
      end
      START: begin
        if (baudEnd) stateNext = DATA;
      end
      DATA: begin
        if (baudEnd) begin
          shiftNext  = {1'b0, rShift[7:1]};
          bitCntNext = rBitCnt + 3'd1;
          if (rBitCnt == 3'd7) begin
`ifdef LED_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef LED_TX_PARITY_EN
      PARITY: begin
        if (baudEnd) stateNext = STOP;
      end
`endif
      STOP: begin
        if (baudEnd) begin
          // Chain straight into the next start bit so queued bytes go out gap-free
          if (!fifoEmpty) begin
            pop        = 1'b1;
            shiftNext  = rMem[rRdPtr];
            bitCntNext = '0;
            stateNext  = START;
`ifdef LED_TX_PARITY_EN
            parityNext = ^rMem[rRdPtr];
`endif
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
`ifdef LED_TX_PARITY_EN
      PARITY:  txNext = parityNext;
`endif
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rState    <= IDLE;
      rBaud     <= '0;
      rBitCnt   <= '0;
      rShift    <= '0;
      rTx       <= 1'b1;
      rOverflow <= 1'b0;
      rLast     <= '0;
      rWrPtr    <= '0;
      rRdPtr    <= '0;
      rCount    <= '0;
`ifdef LED_TX_PARITY_EN
      rParity   <= 1'b0;
`endif
    end else begin
      rState  <= stateNext;
      rBaud   <= baudNext;
      rBitCnt <= bitCntNext;
      rShift  <= shiftNext;
      rTx     <= txNext;
`ifdef LED_TX_PARITY_EN
      rParity <= parityNext;
`endif
      // A dropped change still updates rLast so it is never retried
      if (change) rLast <= iLed;
      if (change && fifoFull) rOverflow <= 1'b1;
      if (doPush) rWrPtr <= rWrPtr + 1'b1;
      if (pop)    rRdPtr <= rRdPtr + 1'b1;
      case ({doPush, pop})
        2'b10:   rCount <= rCount + 1'b1;
        2'b01:   rCount <= rCount - 1'b1;
        default: rCount <= rCount;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset && doPush) rMem[rWrPtr] <= iLed;
  end

  assign oTx        = rTx;
  assign oBusy      = (rState != IDLE);
  assign oOverflow  = rOverflow;
  assign oFifoCount = rCount;

endmodule

// File: doc/led_uart_tx.md
# led_uart_tx

Downstream consumer of the MiniAlu LED port. It watches the 8-bit LED bus and queues every change of value in a small FIFO. It then serialises each queued byte as an asynchronous UART frame on a single pin, so a host terminal can log the program's LED writes without missing fast updates. It has no handshake back to the ALU: it samples the bus every cycle and must never stall the core.

## Interface
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200). Legal values are ≥ 2.
- FIFO_AW, 3: FIFO address width. Depth is 2^FIFO_AW (default 8).

- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset: one clock; reset is synchronous and active-low.
- iLed  in  8  LED value driven by the ALU LED register.
- oTx  out  1  UART line, idle high; 8 data bits LSB first, then 1 stop bit.
- oBusy  out  1  high whenever the transmit FSM is not in IDLE.
- oOverflow  out  1  sticky; set when a change is dropped because the FIFO is full.
- oFifoCount  out  FIFO_AW+1  number of queued bytes, from 0 to 2^FIFO_AW.

## Operation
- **Change detector**
  - Register rLast, reset value 0x00.
  - Each edge where iLed != rLast: rLast <= iLed and push iLed into the FIFO.
  - A push that finds the FIFO full is dropped and sets oOverflow. rLast is still updated, so the dropped value is not retried.
- **FIFO**
  - Circular buffer with pointers of FIFO_AW bits that wrap modulo depth; the count is kept separately.
  - "Full" and "empty" are evaluated from the count before the edge.
  - Simultaneous push and pop with count not full: count unchanged, both take effect.
  - When full, the push is dropped even if a pop occurs on the same edge.
- **Transmit FSM**: states IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: if the FIFO is not empty, pop into shift register rShift, clear the bit counter and the baud counter, go to START.
  - START: oTx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: oTx=rShift[0]; shift right every CLKS_PER_BIT cycles. After 8 bits go to PARITY or STOP.
  - STOP: oTx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- oTx is registered; there is no combinational path from iLed to oTx.
- **Reset values**: oTx=1, oBusy=0, oOverflow=0, oFifoCount=0, state IDLE, rLast=0x00, pointers 0.
- **Reset mid-frame**: the frame is aborted, oTx=1 on the next edge, and queued data is discarded.
- If iLed is nonzero when reset is released, the first post-reset edge detects a change and queues the value.

## Timing
- Push: iLed differs at edge N → the byte is in the FIFO and oFifoCount increments after edge N.
- First frame: the FSM pops at edge N+1, so oTx is low from edge N+1. Latency from change to start bit is 2 edges.
- Frame length:
  - 10×CLKS_PER_BIT cycles without the macro.
  - 11×CLKS_PER_BIT cycles with the macro.
- Back-to-back frames are contiguous, and oBusy stays high between them.
- oBusy falls on the edge that ends the last stop bit.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. A bit advances on the edge where the count equals CLKS_PER_BIT-1.

## Configuration
- Macro: LED_TX_PARITY_EN.
- **Defined**: PARITY state inserted after DATA. oTx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame format is 8E1.
- **Undefined**: no PARITY state, no parity logic. Frame format is 8N1.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_AW=3.
- **Reset**: hold Reset=0 for 3 edges with iLed=0x00 → oTx=1, oBusy=0, oOverflow=0, oFifoCount=0.
- **Single frame**: iLed steps 0x00→0xA5 and is held.
  - oTx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
  - 40 cycles total, one frame only.
  - oBusy=0 after the frame ends.
- **Static input**: iLed held at 0x3C for 200 cycles after a prior change → exactly one frame, oFifoCount returns to 0.
- **Overflow**: 10 distinct values, one per edge.
  - After the 9th push, oFifoCount=8 (full).
  - The 10th push is dropped and oOverflow=1.
  - Exactly 9 contiguous frames carry the first 9 values in order.
- **Mid-frame reset**: Reset=0 at cycle 15 of the 0xA5 frame → oTx=1 and oFifoCount=0 next edge. After release with iLed=0xA5, a new 0xA5 frame starts 2 edges later.
- **Parity (LED_TX_PARITY_EN defined)**:
  - 0xA5 → parity bit 0, 44-cycle frame.
  - 0x01 → parity bit 1.
